// File: rtl/fsm_ser_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Holds the state encoding, the default sizing and the frame-length clamp.
package fsm_ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 2;
    localparam int DEF_LEN_W = 4;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/ser_down_cnt.sv
// Loadable saturating down-counter with a zero flag; load wins over decrement.
// Single-cycle update, no backpressure.
module ser_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fsm_ser_pattern_tx.sv
// MSB-first serializer: bit k of a frame is on ser_out k+1 cycles after accept, then GAP idle cycles.
// Accepts only in IDLE (in_ready); requests arriving while busy are ignored, never buffered.
module fsm_ser_pattern_tx
    import fsm_ser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] frame_len,
    output logic             in_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_nxt_shift;
    logic             r_ser;
    logic             w_nxt_ser;
    logic             r_done;
    logic             w_nxt_done;
    logic             r_busy;
    logic             r_ready;

    logic [LEN_W-1:0] w_len_c;
    logic [LEN_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_aligned;
    logic             w_bit_load;
    logic [LEN_W-1:0] w_bit_val;
    logic             w_bit_dec;
    logic             w_bit_zero;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic             w_gap_zero;

    // Left-align the selected field so the first bit is always the register MSB.
    assign w_len_c   = LEN_W'(clamp_len(32'(frame_len), WIDTH));
    assign w_shamt   = LEN_W'(WIDTH) - w_len_c;
    assign w_aligned = in_data << w_shamt;

    ser_down_cnt #(.W(LEN_W)) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_bit_load),
        .i_load_val (w_bit_val),
        .i_dec      (w_bit_dec),
        .o_zero     (w_bit_zero)
    );

    ser_down_cnt #(.W(GW)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_gap_load),
        .i_load_val (GAP_LOAD),
        .i_dec      (w_gap_dec),
        .o_zero     (w_gap_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_ser   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_shift <= w_nxt_shift;
            r_ser   <= w_nxt_ser;
            r_done  <= w_nxt_done;
            r_busy  <= (w_nxt_state != S_IDLE);
            r_ready <= (w_nxt_state == S_IDLE);
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_shift = r_shift;
        w_nxt_ser   = 1'b0;
        w_nxt_done  = 1'b0;
        w_bit_load  = 1'b0;
        w_bit_val   = '0;
        w_bit_dec   = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_len_c != '0) begin
                        w_nxt_state = S_SHIFT;
                        w_nxt_ser   = w_aligned[WIDTH-1];
                        w_nxt_shift = w_aligned << 1;
                        w_bit_load  = 1'b1;
                        w_bit_val   = w_len_c - 1'b1;
                    end else begin
                        w_nxt_done = 1'b1;
                        if (GAP > 0) begin
                            w_nxt_state = S_GAP;
                            w_gap_load  = 1'b1;
                        end
                    end
                end
            end
            S_SHIFT: begin
                // Counter holds bits still to send after the one now on the wire.
                if (w_bit_zero) begin
                    w_nxt_done = 1'b1;
                    if (GAP > 0) begin
                        w_nxt_state = S_GAP;
                        w_gap_load  = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_ser   = r_shift[WIDTH-1];
                    w_nxt_shift = r_shift << 1;
                    w_bit_dec   = 1'b1;
                end
            end
            S_GAP: begin
                if (w_gap_zero) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign in_ready = r_ready;
    assign ser_out  = r_ser;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_fsm_ser_pattern_tx.sv
// Directed bench for fsm_ser_pattern_tx: a GAP=2 instance and a GAP=0 instance.
module tb_fsm_ser_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] frame_len;
    logic       in_ready, ser_out, busy, done;

    logic       g0_valid;
    logic [7:0] g0_data;
    logic [3:0] g0_len;
    logic       g0_ready, g0_ser, g0_busy, g0_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fsm_ser_pattern_tx #(.WIDTH(8), .GAP(2), .LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .frame_len (frame_len),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    fsm_ser_pattern_tx #(.WIDTH(8), .GAP(0), .LEN_W(4)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (g0_valid),
        .in_data   (g0_data),
        .frame_len (g0_len),
        .in_ready  (g0_ready),
        .ser_out   (g0_ser),
        .busy      (g0_busy),
        .done      (g0_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Called in cycle 1 after the accept edge; returns in the first in_ready cycle.
    task automatic expect_frame(input string tag, input logic [7:0] exp_seq, input int n, input int gap);
        int last;
        last = n + gap + 1;
        for (int c = 1; c <= last; c++) begin
            check($sformatf("%s ser c%0d", tag, c),   ser_out,  (c <= n) ? exp_seq[n-c] : 1'b0);
            check($sformatf("%s done c%0d", tag, c),  done,     c == n + 1);
            check($sformatf("%s ready c%0d", tag, c), in_ready, c == last);
            check($sformatf("%s busy c%0d", tag, c),  busy,     c != last);
            if (c < last) tick();
        end
    endtask

    initial begin
        logic [5:0] g0_exp_ser;
        logic [5:0] g0_exp_done;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        frame_len = 4'd0;
        g0_valid  = 1'b0;
        g0_data   = 8'h00;
        g0_len    = 4'd0;

        tick();
        tick();
        check("rst ser", ser_out, 1'b0);
        check("rst ready", in_ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst g0 ready", g0_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Full 8-bit frame; in_data scribbled after accept.
        in_valid = 1'b1; in_data = 8'b1011_0010; frame_len = 4'd8;
        tick();
        in_valid = 1'b0; in_data = 8'hFF;
        expect_frame("f8", 8'b1011_0010, 8, 2);

        // Short frame: only bits [2:0] of 0xF5 = 101.
        in_valid = 1'b1; in_data = 8'hF5; frame_len = 4'd3;
        tick();
        in_valid = 1'b0;
        expect_frame("f3", 8'b0000_0101, 3, 2);

        // in_valid held: second word taken right when in_ready returns.
        in_valid = 1'b1; in_data = 8'h96; frame_len = 4'd5;
        tick();
        in_data = 8'h3C;
        expect_frame("b2b1", 8'b0001_0110, 5, 2);
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        expect_frame("b2b2", 8'b0001_1100, 5, 2);

        // Zero-length frame.
        in_valid = 1'b1; in_data = 8'hFF; frame_len = 4'd0;
        tick();
        in_valid = 1'b0;
        expect_frame("f0", 8'h00, 0, 2);

        // Oversized length clamps to the full word.
        in_valid = 1'b1; in_data = 8'hA5; frame_len = 4'd15;
        tick();
        in_valid = 1'b0;
        expect_frame("clamp", 8'b1010_0101, 8, 2);

        // Reset on the 4th bit aborts the frame without a done pulse.
        in_valid = 1'b1; in_data = 8'hFF; frame_len = 4'd8;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("abort ser c%0d", c), ser_out, 1'b1);
            if (c < 4) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort ser", ser_out, 1'b0);
        check("abort ready", in_ready, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("abort quiet done c%0d", c), done, 1'b0);
            check($sformatf("abort quiet ser c%0d", c), ser_out, 1'b0);
        end
        in_valid = 1'b1; in_data = 8'h02; frame_len = 4'd2;
        tick();
        in_valid = 1'b0;
        expect_frame("post", 8'b0000_0010, 2, 2);

        // GAP=0 build: frames 10 and 01 back to back.
        g0_exp_ser  = 6'b100010;
        g0_exp_done = 6'b001001;
        g0_valid = 1'b1; g0_data = 8'b10; g0_len = 4'd2;
        tick();
        g0_data = 8'b01;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("g0 ser c%0d", c),   g0_ser,   g0_exp_ser[6-c]);
            check($sformatf("g0 done c%0d", c),  g0_done,  g0_exp_done[6-c]);
            check($sformatf("g0 ready c%0d", c), g0_ready, g0_exp_done[6-c]);
            check($sformatf("g0 busy c%0d", c),  g0_busy,  !g0_exp_done[6-c]);
            if (c == 4) g0_valid = 1'b0;
            if (c < 6) tick();
        end
        tick();
        check("g0 idle ready", g0_ready, 1'b1);
        check("g0 idle ser", g0_ser, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_ser_pattern_tx.md
Name: fsm_ser_pattern_tx

Overview:
- Serial pattern transmitter: the drive side of the one-bit serial link consumed by the sorted-pair detector FSM.
- Accepts a parallel word and a bit count through a valid/ready handshake, then shifts the bits out MSB-first on `ser_out`, one bit per clock.
- After each frame it inserts a fixed idle gap.
- Used as the on-chip stimulus source feeding detector FSMs, and as a reusable serializer.

Parameters:
- WIDTH, 8, maximum frame length in bits; data word width.
- GAP, 2, idle cycles (`ser_out`=0) forced after every frame; 0 is legal.
- LEN_W, 4, width of `frame_len`; must satisfy 2^LEN_W > WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  frame request valid.
- in_data  input  WIDTH  frame bits; bits [frame_len-1:0] are sent, MSB of that field first.
- frame_len  input  LEN_W  number of bits to send, 0..WIDTH.
- in_ready  output  1  high only when idle; a frame is accepted on the edge where in_valid && in_ready.
- ser_out  output  1  registered serial data.
- busy  output  1  high from acceptance until return to IDLE.
- done  output  1  one-cycle pulse marking the end of the frame's data bits.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: ser_out=0, in_ready=1, busy=0, done=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts the frame. The cycle after the reset edge shows the reset values, and no done pulse is emitted.
- All outputs are registered. in_ready is 1 exactly when state==IDLE.
- States:
  - IDLE: ser_out=0. On in_valid, capture in_data and frame_len.
    - frame_len>=1: go to SHIFT.
    - frame_len==0: go to GAP (or stay in IDLE if GAP==0) with done=1 next cycle, and no data bits.
    - frame_len>WIDTH: clamped to WIDTH.
  - SHIFT: ser_out drives the current bit.
    - The bit counter counts down from frame_len.
    - After the last bit, go to GAP (GAP>0) or IDLE (GAP==0).
    - done=1 in the first cycle after the last data bit.
  - GAP: ser_out=0 for exactly GAP cycles, then go to IDLE.
- Latency, with T0 the accept edge:
  - Bit k (k=0 is in_data[frame_len-1]) is on ser_out during the cycle after edge T0+k.
  - After edge T0+frame_len: ser_out=0 and done=1 for one cycle.
  - in_ready rises after edge T0+frame_len+GAP.
- in_valid and in_data are ignored while in_ready=0; no buffering of a second request.
- Minimum spacing between accepts is frame_len+GAP+1 cycles.
- in_data changes after acceptance have no effect.
- busy = (state != IDLE). It may be 0 in the same cycle done=1 when GAP==0.

Decomposition:
- Shared package (`fsm_ser_pkg`):
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, GAP=2'd2;
  - default WIDTH/GAP values;
  - a len-clamp function.
- One natural sub-module: `ser_down_cnt`, a loadable down-counter with a zero flag.
  - Instantiated twice: bit counter (LEN_W bits) and gap counter (width clog2(GAP+1)).
- FSM and shift register stay in the top module.

Test Plan:
- Reset held 15 ns, then in_valid with in_data=8'b1011_0010, frame_len=8, GAP=2 -> ser_out = 1,0,1,1,0,0,1,0 on the 8 cycles after accept; done high on cycle 9 only; ser_out=0 for cycles 9-10; in_ready=1 from cycle 11.
- frame_len=3, in_data=8'hF5 -> ser_out = 1,0,1 (bits 2..0); upper bits never appear; done on cycle 4.
- in_valid held high continuously with two different words -> the second is accepted exactly frame_len+GAP+1 cycles after the first; no bit overlap; in_data changes during SHIFT are ignored.
- frame_len=0 -> no data bits; done pulses the cycle after accept; ser_out stays 0; in_ready returns after GAP more cycles.
- rst asserted on the 4th bit of an 8-bit frame -> next cycle ser_out=0, in_ready=1, busy=0; no done pulse; a new frame is accepted normally.
- GAP=0 build, back-to-back frames 2'b10 and 2'b01 -> ser_out = 1,0,0,0,1 (one idle cycle between frames); done pulses on cycles 3 and 6.
